int_responder: RTL and testbench

//  Completion-side counterpart of the interrupt manager's cfg_interrupt handshake.

---
 rtl/int_responder_if.sv | 60 ++++++
 rtl/int_responder.sv | 156 +++++++++++++++
 tb/tb_int_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_responder_if.sv
// Request/response and TX-message signals between the application interrupt
// logic, the int_responder core and the TX message arbiter.
interface int_responder_if;
    logic        msi_on;
    logic [63:0] msi_addr_i;
    logic [15:0] msi_data_i;
    logic        cfg_interrupt_n_i;
    logic        cfg_interrupt_assert_n_i;
    logic        cfg_interrupt_rdy_n_o;
    logic        cfg_interrupt_legacyclr_o;
    logic        msg_req_o;
    logic [1:0]  msg_type_o;
    logic [63:0] msg_addr_o;
    logic [31:0] msg_data_o;
    logic        msg_ack_i;
    logic        intx_asserted_o;
    logic [31:0] msi_cnt_o;
    logic [31:0] intx_cnt_o;
    logic [15:0] drop_cnt_o;

    // The responder core side.
    modport slave (
        input  msi_on,
        input  msi_addr_i,
        input  msi_data_i,
        input  cfg_interrupt_n_i,
        input  cfg_interrupt_assert_n_i,
        output cfg_interrupt_rdy_n_o,
        output cfg_interrupt_legacyclr_o,
        output msg_req_o,
        output msg_type_o,
        output msg_addr_o,
        output msg_data_o,
        input  msg_ack_i,
        output intx_asserted_o,
        output msi_cnt_o,
        output intx_cnt_o,
        output drop_cnt_o
    );

    // The requester / arbiter side.
    modport master (
        output msi_on,
        output msi_addr_i,
        output msi_data_i,
        output cfg_interrupt_n_i,
        output cfg_interrupt_assert_n_i,
        input  cfg_interrupt_rdy_n_o,
        input  cfg_interrupt_legacyclr_o,
        input  msg_req_o,
        input  msg_type_o,
        input  msg_addr_o,
        input  msg_data_o,
        output msg_ack_i,
        input  intx_asserted_o,
        input  msi_cnt_o,
        input  intx_cnt_o,
        input  drop_cnt_o
    );
endinterface

// File: rtl/int_responder.sv
// Interrupt completion responder: turns each cfg_interrupt request into one
// MSI or INTx message towards the TX arbiter and returns a one-cycle rdy strobe.
module int_responder #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int TO_W        = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    int_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_RDY  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [1:0]      TYPE_MSI   = 2'b00;
    localparam logic [1:0]      TYPE_ASSRT = 2'b01;
    localparam logic [1:0]      TYPE_DEASS = 2'b10;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(ACK_TIMEOUT - 1);

    state_t            state_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              rdy_n_reg;
    logic              legacyclr_reg;
    logic              msg_req_reg;
    logic [1:0]        msg_type_reg;
    logic [63:0]       msg_addr_reg;
    logic [31:0]       msg_data_reg;
    logic              intx_reg;
    logic [31:0]       msi_cnt_reg;
    logic [31:0]       intx_cnt_reg;
    logic [15:0]       drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            to_cnt_reg    <= '0;
            rdy_n_reg     <= 1'b1;
            legacyclr_reg <= 1'b0;
            msg_req_reg   <= 1'b0;
            msg_type_reg  <= '0;
            msg_addr_reg  <= '0;
            msg_data_reg  <= '0;
            intx_reg      <= 1'b0;
            msi_cnt_reg   <= '0;
            intx_cnt_reg  <= '0;
            drop_cnt_reg  <= '0;
        end else if (!en) begin
            state_reg     <= ST_IDLE;
            to_cnt_reg    <= '0;
            rdy_n_reg     <= 1'b1;
            legacyclr_reg <= 1'b0;
            msg_req_reg   <= 1'b0;
            msg_type_reg  <= '0;
            msg_addr_reg  <= '0;
            msg_data_reg  <= '0;
            intx_reg      <= 1'b0;
            msi_cnt_reg   <= '0;
            intx_cnt_reg  <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            legacyclr_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!bus.cfg_interrupt_n_i) begin
                        to_cnt_reg <= '0;
                        if (bus.msi_on) begin
                            msg_type_reg <= TYPE_MSI;
                            msg_addr_reg <= bus.msi_addr_i;
                            msg_data_reg <= {16'h0000, bus.msi_data_i};
                            msg_req_reg  <= 1'b1;
                            state_reg    <= ST_MSG;
                        end else if (!bus.cfg_interrupt_assert_n_i && !intx_reg) begin
                            msg_type_reg <= TYPE_ASSRT;
                            msg_addr_reg <= '0;
                            msg_data_reg <= {16'h0000, bus.msi_data_i};
                            msg_req_reg  <= 1'b1;
                            state_reg    <= ST_MSG;
                        end else if (bus.cfg_interrupt_assert_n_i && intx_reg) begin
                            msg_type_reg <= TYPE_DEASS;
                            msg_addr_reg <= '0;
                            msg_data_reg <= {16'h0000, bus.msi_data_i};
                            msg_req_reg  <= 1'b1;
                            state_reg    <= ST_MSG;
                        end else begin
                            // Wire already in the requested state: nothing to send,
                            // the strobe is raised from ST_RDY one cycle later.
                            state_reg <= ST_RDY;
                        end
                    end
                end

                ST_MSG: begin
                    if (bus.msg_ack_i) begin
                        msg_req_reg <= 1'b0;
                        rdy_n_reg   <= 1'b0;
                        state_reg   <= ST_RDY;
                        case (msg_type_reg)
                            TYPE_MSI: msi_cnt_reg <= msi_cnt_reg + 32'd1;
                            TYPE_ASSRT: begin
                                intx_reg     <= 1'b1;
                                intx_cnt_reg <= intx_cnt_reg + 32'd1;
                            end
                            TYPE_DEASS: begin
                                intx_reg      <= 1'b0;
                                intx_cnt_reg  <= intx_cnt_reg + 32'd1;
                                legacyclr_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (to_cnt_reg == TO_LAST) begin
                        msg_req_reg <= 1'b0;
                        rdy_n_reg   <= 1'b0;
                        state_reg   <= ST_RDY;
                        if (drop_cnt_reg != 16'hFFFF) begin
                            drop_cnt_reg <= drop_cnt_reg + 16'd1;
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                ST_RDY: begin
                    // Entered either with the strobe already low (message done)
                    // or still high (redundant INTx) -- strobe exactly once.
                    if (rdy_n_reg) begin
                        rdy_n_reg <= 1'b0;
                    end else begin
                        rdy_n_reg <= 1'b1;
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: state_reg <= ST_IDLE;

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_interrupt_rdy_n_o     = rdy_n_reg;
    assign bus.cfg_interrupt_legacyclr_o = legacyclr_reg;
    assign bus.msg_req_o                 = msg_req_reg;
    assign bus.msg_type_o                = msg_type_reg;
    assign bus.msg_addr_o                = msg_addr_reg;
    assign bus.msg_data_o                = msg_data_reg;
    assign bus.intx_asserted_o           = intx_reg;
    assign bus.msi_cnt_o                 = msi_cnt_reg;
    assign bus.intx_cnt_o                = intx_cnt_reg;
    assign bus.drop_cnt_o                = drop_cnt_reg;

endmodule

// File: tb/tb_int_responder.sv
// Randomised bench for int_responder: each request is predicted at transaction
// level (message or not, type, fields, ack/timeout outcome, counters, wire state).
module tb_int_responder;

    localparam int ACK_TO = 8;

    logic clk;
    logic rst;
    logic en;

    int_responder_if b ();

    int_responder #(
        .ACK_TIMEOUT (ACK_TO),
        .TO_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Transaction-level reference state.
    bit          m_intx;
    int unsigned m_msi_cnt;
    int unsigned m_intx_cnt;
    int unsigned m_drop_cnt;
    int          txn_no = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_intx     = 1'b0;
        m_msi_cnt  = 0;
        m_intx_cnt = 0;
        m_drop_cnt = 0;
    endtask

    task automatic chk_state(input string pfx);
        chk({pfx, "_intx"},     64'(b.intx_asserted_o), 64'(m_intx));
        chk({pfx, "_msi_cnt"},  64'(b.msi_cnt_o),       64'(m_msi_cnt));
        chk({pfx, "_intx_cnt"}, 64'(b.intx_cnt_o),      64'(m_intx_cnt));
        chk({pfx, "_drop_cnt"}, 64'(b.drop_cnt_o),      64'(m_drop_cnt));
    endtask

    // Called at a negedge while the DUT sits in ST_IDLE. d = cycle of msg_req
    // (0 = first) in which ack is given; d >= ACK_TO means never ack.
    task automatic do_txn(input bit msi, input bit asn, input logic [63:0] a,
                          input logic [15:0] dt, input int d, input bit keep_low);
        bit         exp_msg;
        logic [1:0] et;
        int         hi;
        bit         acked;
        string      outcome;

        if (msi)       exp_msg = 1'b1;
        else if (!asn) exp_msg = !m_intx;
        else           exp_msg = m_intx;
        et = msi ? 2'b00 : (asn ? 2'b10 : 2'b01);

        b.msi_on                   = msi;
        b.cfg_interrupt_assert_n_i = asn;
        b.msi_addr_i               = a;
        b.msi_data_i               = dt;
        b.cfg_interrupt_n_i        = 1'b0;
        b.msg_ack_i                = 1'b0;
        @(negedge clk);
        // Inputs must have been captured at accept; disturb them now.
        b.msi_on                   = 1'($urandom);
        b.cfg_interrupt_assert_n_i = 1'($urandom);
        b.msi_addr_i               = {$urandom, $urandom};
        b.msi_data_i               = 16'($urandom);

        if (exp_msg) begin
            chk("req_up",   64'(b.msg_req_o),  64'd1);
            chk("type",     64'(b.msg_type_o), 64'(et));
            chk("addr",     b.msg_addr_o,      msi ? a : 64'd0);
            chk("data",     64'(b.msg_data_o), {48'd0, dt});
            chk("rdy_early", 64'(b.cfg_interrupt_rdy_n_o), 64'd1);
            hi    = 0;
            acked = 1'b0;
            for (int i = 0; i < ACK_TO; i++) begin
                if (b.msg_req_o === 1'b1) hi++;
                if (i == d) begin
                    b.msg_ack_i = 1'b1;
                    acked       = 1'b1;
                end
                @(negedge clk);
                b.msg_ack_i = 1'b0;
                if (acked) break;
            end
            chk("req_len",   64'(hi), acked ? 64'(d + 1) : 64'(ACK_TO));
            chk("req_down",  64'(b.msg_req_o), 64'd0);
            chk("rdy_msg",   64'(b.cfg_interrupt_rdy_n_o), 64'd0);
            chk("legacyclr", 64'(b.cfg_interrupt_legacyclr_o), 64'(acked && et == 2'b10));
            if (acked) begin
                if (msi) m_msi_cnt++;
                else begin
                    m_intx_cnt++;
                    m_intx = (et == 2'b01);
                end
                outcome = "acked";
            end else begin
                if (m_drop_cnt < 32'hFFFF) m_drop_cnt++;
                outcome = "dropped";
            end
        end else begin
            chk("no_req",   64'(b.msg_req_o), 64'd0);
            chk("rdy_wait", 64'(b.cfg_interrupt_rdy_n_o), 64'd1);
            b.msg_ack_i = 1'($urandom);
            @(negedge clk);
            b.msg_ack_i = 1'b0;
            chk("rdy_red",  64'(b.cfg_interrupt_rdy_n_o), 64'd0);
            chk("no_clr",   64'(b.cfg_interrupt_legacyclr_o), 64'd0);
            chk("no_req2",  64'(b.msg_req_o), 64'd0);
            outcome = "redundant";
        end

        if (!keep_low) b.cfg_interrupt_n_i = 1'b1;
        @(negedge clk);
        chk("rdy_one", 64'(b.cfg_interrupt_rdy_n_o), 64'd1);
        chk("clr_one", 64'(b.cfg_interrupt_legacyclr_o), 64'd0);
        chk_state("post");
        @(negedge clk);
        chk("idle_req", 64'(b.msg_req_o), 64'd0);
        chk("idle_rdy", 64'(b.cfg_interrupt_rdy_n_o), 64'd1);
        txn_no++;
        $display("txn %0d: msi=%0d asn=%0d type=%0d ack_at=%0d -> %s intx=%0d msi_cnt=%0d intx_cnt=%0d drop=%0d",
                 txn_no, msi, asn, et, d, outcome, m_intx, m_msi_cnt, m_intx_cnt, m_drop_cnt);
    endtask

    initial begin
        rst                        = 1'b1;
        en                         = 1'b1;
        b.msi_on                   = 1'b0;
        b.msi_addr_i               = '0;
        b.msi_data_i               = '0;
        b.cfg_interrupt_n_i        = 1'b1;
        b.cfg_interrupt_assert_n_i = 1'b1;
        b.msg_ack_i                = 1'b0;
        model_clear();
        #1;
        chk("rst_rdy",  64'(b.cfg_interrupt_rdy_n_o), 64'd1);
        chk("rst_clr",  64'(b.cfg_interrupt_legacyclr_o), 64'd0);
        chk("rst_req",  64'(b.msg_req_o), 64'd0);
        chk("rst_type", 64'(b.msg_type_o), 64'd0);
        chk("rst_addr", b.msg_addr_o, 64'd0);
        chk("rst_data", 64'(b.msg_data_o), 64'd0);
        chk_state("rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: MSI with late ack, INTx assert/deassert, redundant, timeout, back-to-back.
        do_txn(1'b1, 1'b1, 64'h0000_0001_FEE0_0000, 16'h0041, 3, 1'b0);
        do_txn(1'b0, 1'b0, 64'h0, 16'h0, 0, 1'b0);
        do_txn(1'b0, 1'b0, 64'h0, 16'h0, 0, 1'b0);
        do_txn(1'b0, 1'b1, 64'h0, 16'h0, 0, 1'b0);
        do_txn(1'b0, 1'b1, 64'h0, 16'h0, 0, 1'b0);
        do_txn(1'b1, 1'b0, 64'hDEAD_BEEF_0000_1234, 16'h5A5A, 20, 1'b0);
        do_txn(1'b1, 1'b0, 64'h0, 16'hFFFF, ACK_TO - 1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            do_txn(1'b1, 1'b0, {32'h0, 32'hFEE0_0000 + 32'(k)}, 16'(k), 0, 1'b1);
        end
        b.cfg_interrupt_n_i = 1'b1;
        @(negedge clk);

        // Randomised mix.
        for (int k = 0; k < 60; k++) begin
            do_txn(($urandom_range(0, 2) == 0), 1'($urandom), {$urandom, $urandom},
                   16'($urandom), int'($urandom_range(0, ACK_TO + 2)),
                   ($urandom_range(0, 3) == 0));
        end
        b.cfg_interrupt_n_i = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a message.
        b.msi_on            = 1'b1;
        b.msi_addr_i        = 64'h1234;
        b.msi_data_i        = 16'h7;
        b.cfg_interrupt_n_i = 1'b0;
        @(negedge clk);
        chk("mid_req_up", 64'(b.msg_req_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk("arst_req",  64'(b.msg_req_o), 64'd0);
        chk("arst_rdy",  64'(b.cfg_interrupt_rdy_n_o), 64'd1);
        chk("arst_addr", b.msg_addr_o, 64'd0);
        chk_state("arst");
        b.cfg_interrupt_n_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("arst_no_rdy", 64'(b.cfg_interrupt_rdy_n_o), 64'd1);
        end

        // Synchronous clear through en.
        do_txn(1'b0, 1'b0, 64'h0, 16'h0, 1, 1'b0);
        do_txn(1'b1, 1'b0, 64'h99, 16'h3, 2, 1'b0);
        en = 1'b0;
        @(negedge clk);
        model_clear();
        chk_state("en_clr");
        en = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 1'b1, 64'h0, 16'h0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
